// File: rtl/ula_pkg.sv
// Shared opcode and FSM state types for the sequential ULA.
// Used by ula_nbit_seq and ula_mul_seq.
package ula_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SLT = 3'b101,
        OP_MUL = 3'b110,
        OP_RSV = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/ula_mul_seq.sv
// Shift-add unsigned multiplier: WIDTH steps after start.
// done is high during the last step; prod is the final product then.
module ula_mul_seq
    import ula_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] prod
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [WIDTH:0]     step_sum;
    logic [CW-1:0]      cnt;
    logic               busy;

    // acc holds {partial high, remaining multiplier bits}
    always_comb begin
        step_sum = {1'b0, acc[2*WIDTH-1:WIDTH]};
        if (acc[0]) begin
            step_sum = step_sum + {1'b0, mcand};
        end
        acc_nxt = {step_sum, acc[WIDTH-1:1]};
    end

    assign done = busy && (cnt == LAST);
    assign prod = acc_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand <= '0;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
        end else if (start) begin
            mcand <= a;
            acc   <= {{WIDTH{1'b0}}, b};
            cnt   <= '0;
            busy  <= 1'b1;
        end else if (busy) begin
            acc <= acc_nxt;
            cnt <= cnt + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ula_nbit_seq.sv
// Registered WIDTH-bit ULA with valid/ready handshakes and flags.
// Define ULA_MUL_EN to build the multi-cycle unsigned multiplier.
module ula_nbit_seq
    import ula_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic [WIDTH-1:0] res_hi,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v,
    output logic             err
);

    state_t state, state_nxt;
    op_t    opc;
    logic   accept;
    logic   is_mul;
    logic   mul_done;

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic             alu_err;

    assign opc       = op_t'(op);
    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign accept    = in_ready && in_valid;

`ifdef ULA_MUL_EN
    logic [2*WIDTH-1:0] mul_prod;

    assign is_mul = (opc == OP_MUL);

    ula_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (accept && is_mul),
        .a     (a),
        .b     (b),
        .done  (mul_done),
        .prod  (mul_prod)
    );
`else
    assign is_mul   = 1'b0;
    assign mul_done = 1'b0;
`endif

    // SUB is a + ~b + 1 so carry doubles as no-borrow
    always_comb begin
        b_eff   = (opc == OP_SUB) ? ~b : b;
        sum     = {1'b0, a} + {1'b0, b_eff}
                + {{WIDTH{1'b0}}, (opc == OP_SUB)};
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_err = 1'b0;
        unique case (1'b1)
            (opc == OP_ADD), (opc == OP_SUB): begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (a[WIDTH-1] == b_eff[WIDTH-1])
                        && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            (opc == OP_AND): alu_res = a & b;
            (opc == OP_OR):  alu_res = a | b;
            (opc == OP_XOR): alu_res = a ^ b;
            (opc == OP_SLT): begin
                alu_res = {{(WIDTH-1){1'b0}},
                           ($signed(a) < $signed(b))};
            end
            default: alu_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    state_nxt = is_mul ? S_BUSY : S_DONE;
                end
            end
            S_BUSY: begin
                if (mul_done) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res    <= '0;
            res_hi <= '0;
            flag_z <= 1'b0;
            flag_n <= 1'b0;
            flag_c <= 1'b0;
            flag_v <= 1'b0;
            err    <= 1'b0;
        end else if (accept && !is_mul) begin
            res    <= alu_res;
            res_hi <= '0;
            flag_z <= (alu_res == '0);
            flag_n <= alu_res[WIDTH-1];
            flag_c <= alu_c;
            flag_v <= alu_v;
            err    <= alu_err;
        end
`ifdef ULA_MUL_EN
        else if (mul_done) begin
            res    <= mul_prod[WIDTH-1:0];
            res_hi <= mul_prod[2*WIDTH-1:WIDTH];
            flag_z <= (mul_prod[WIDTH-1:0] == '0);
            flag_n <= mul_prod[WIDTH-1];
            flag_c <= 1'b0;
            flag_v <= 1'b0;
            err    <= 1'b0;
        end
`endif
    end

endmodule

// File: tb/tb_ula_nbit_seq.sv
// Directed scoreboard bench for ula_nbit_seq at WIDTH=8.
// Expectations follow ULA_MUL_EN when it is defined.
module tb_ula_nbit_seq;
    import ula_pkg::*;

    typedef struct {
        logic [7:0] res;
        logic [7:0] hi;
        logic       z;
        logic       n;
        logic       c;
        logic       v;
        logic       err;
        int         lat;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] res;
    logic [7:0] res_hi;
    logic       flag_z;
    logic       flag_n;
    logic       flag_c;
    logic       flag_v;
    logic       err;

    int   checks;
    int   errors;
    exp_t sb[$];

    ula_nbit_seq #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .res_hi    (res_hi),
        .flag_z    (flag_z),
        .flag_n    (flag_n),
        .flag_c    (flag_c),
        .flag_v    (flag_v),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] r, input logic [7:0] h,
                                input logic z, input logic n,
                                input logic c, input logic v,
                                input logic e, input int l);
        exp_t x;
        x.res = r;
        x.hi  = h;
        x.z   = z;
        x.n   = n;
        x.c   = c;
        x.v   = v;
        x.err = e;
        x.lat = l;
        return x;
    endfunction

    task automatic cmp_out(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_res"}, res, e.res);
            chk({tag, "_res_hi"}, res_hi, e.hi);
            chk({tag, "_z"}, flag_z, e.z);
            chk({tag, "_n"}, flag_n, e.n);
            chk({tag, "_c"}, flag_c, e.c);
            chk({tag, "_v"}, flag_v, e.v);
            chk({tag, "_err"}, err, e.err);
        end
    endtask

    // drives one op with out_ready=1 and checks result and latency
    task automatic do_op(input string tag, input logic [2:0] o,
                         input logic [7:0] x, input logic [7:0] y,
                         input exp_t e);
        int lat;
        chk({tag, "_in_ready"}, in_ready, 1'b1);
        in_valid = 1'b1;
        op = o;
        a = x;
        b = y;
        sb.push_back(e);
        tick();
        in_valid = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        op = 3'($urandom);
        lat = 1;
        while (!out_valid && lat < 50) begin
            chk({tag, "_busy_in_ready"}, in_ready, 1'b0);
            tick();
            lat++;
        end
        chk({tag, "_latency"}, lat, e.lat);
        cmp_out(tag);
        tick();
        chk({tag, "_ov_drop"}, out_valid, 1'b0);
        chk({tag, "_idle"}, in_ready, 1'b1);
    endtask

    initial begin
        bit seen;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        op = '0;
        out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_res", res, 8'h00);
        chk("rst_res_hi", res_hi, 8'h00);
        chk("rst_flags", {flag_z, flag_n, flag_c, flag_v, err}, 5'b0);

        do_op("sub_107_86", 3'b001, 8'd107, 8'd86,
              mk(8'd21, 8'h00, 0, 0, 1, 0, 0, 1));
        do_op("add_86_107", 3'b000, 8'd86, 8'd107,
              mk(8'hC1, 8'h00, 0, 1, 0, 1, 0, 1));
        do_op("add_ff_01", 3'b000, 8'hFF, 8'h01,
              mk(8'h00, 8'h00, 1, 0, 1, 0, 0, 1));
        do_op("and_aa_55", 3'b010, 8'hAA, 8'h55,
              mk(8'h00, 8'h00, 1, 0, 0, 0, 0, 1));
        do_op("or_aa_55", 3'b011, 8'hAA, 8'h55,
              mk(8'hFF, 8'h00, 0, 1, 0, 0, 0, 1));
        do_op("xor_0f_ff", 3'b100, 8'h0F, 8'hFF,
              mk(8'hF0, 8'h00, 0, 1, 0, 0, 0, 1));
        do_op("slt_80_01", 3'b101, 8'h80, 8'h01,
              mk(8'h01, 8'h00, 0, 0, 0, 0, 0, 1));
        do_op("slt_01_80", 3'b101, 8'h01, 8'h80,
              mk(8'h00, 8'h00, 1, 0, 0, 0, 0, 1));
        do_op("sub_00_01", 3'b001, 8'h00, 8'h01,
              mk(8'hFF, 8'h00, 0, 1, 0, 0, 0, 1));
        do_op("sub_80_01", 3'b001, 8'h80, 8'h01,
              mk(8'h7F, 8'h00, 0, 0, 1, 1, 0, 1));
        do_op("rsv", 3'b111, 8'h05, 8'h03,
              mk(8'h00, 8'h00, 1, 0, 0, 0, 1, 1));
`ifdef ULA_MUL_EN
        do_op("mul_200_3", 3'b110, 8'd200, 8'd3,
              mk(8'h58, 8'h02, 0, 0, 0, 0, 0, 9));
        do_op("mul_ff_ff", 3'b110, 8'hFF, 8'hFF,
              mk(8'h01, 8'hFE, 0, 0, 0, 0, 0, 9));
`else
        do_op("mul_off", 3'b110, 8'd200, 8'd3,
              mk(8'h00, 8'h00, 1, 0, 0, 0, 1, 1));
`endif

        // backpressure: result held, new requests ignored
        out_ready = 1'b0;
        in_valid = 1'b1;
        op = 3'b000;
        a = 8'd1;
        b = 8'd2;
        sb.push_back(mk(8'd3, 8'h00, 0, 0, 0, 0, 0, 1));
        tick();
        a = 8'd50;
        b = 8'd50;
        chk("bp_out_valid", out_valid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_res", res, 8'd3);
            chk("bp_hold_valid", out_valid, 1'b1);
            chk("bp_in_ready", in_ready, 1'b0);
            if (i < 4) tick();
        end
        cmp_out("bp");
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_release_ov", out_valid, 1'b0);
        chk("bp_release_ir", in_ready, 1'b1);
        tick();
        chk("bp_no_ghost", out_valid, 1'b0);

        // reset during an in-flight multiply (or a held result)
        out_ready = 1'b0;
        in_valid = 1'b1;
        op = 3'b110;
        a = 8'd200;
        b = 8'd3;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_out_valid", out_valid, 1'b0);
        chk("mrst_in_ready", in_ready, 1'b1);
        chk("mrst_res", {res_hi, res}, 16'h0000);
        chk("mrst_flags", {flag_z, flag_n, flag_c, flag_v, err}, 5'b0);
        out_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) seen = 1'b1;
            tick();
        end
        chk("mrst_no_output", seen, 1'b0);
        do_op("sub_8_4", 3'b001, 8'd8, 8'd4,
              mk(8'd4, 8'h00, 0, 0, 1, 0, 0, 1));

        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
